cart_bus_master: RTL and testbench
==================================

Name: cart_bus_master

Overview:
- Console-side initiator that runs timed Game Boy cartridge read and write cycles on the physical cartridge pins.
- Used for dumping and restoring Camera ROM and cart RAM, and for probing mapper registers, outside normal CPU execution.
- Talks to the same pin bundle (cart_tran_bank0..3) the cartridge mapper logic drives.
- Front end is a simple request/busy/done handshake.

Parameters:
- PHASE_CYCLES, 4: clk_sys cycles per bus phase. Legal range 1..255.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  1  start a transaction; sampled only when busy=0
- req_we  in  1  1 = write, 0 = read; captured with req
- req_addr  in  16  cartridge address; captured with req
- req_wdata  in  8  write data; captured with req
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at transaction end
- rdata  out  8  read data; valid from done until the next done
- cart_tran_bank0_out  out  [7:4]  {PHI, nWR, nRD, nCS}
- cart_tran_bank1_in  in  8  cartridge data bus input
- cart_tran_bank1_out  out  8  cartridge data bus output
- cart_tran_bank1_dir  out  1  1 = FPGA drives the data bus
- cart_tran_bank2_out  out  8  A[15:8]
- cart_tran_bank3_out  out  8  A[7:0]

Behaviour:
- Reset values (applied on the next clk_sys edge with reset=1, including mid-transaction):
  - busy=0, done=0, rdata=0x00.
  - bank0_out=4'b0111 (PHI=0, nWR=1, nRD=1, nCS=1).
  - bank1_out=0x00, bank1_dir=0, bank2/bank3_out=0x00.
  - FSM returns to IDLE. An aborted transaction produces no done.
- FSM: IDLE -> SETUP -> STROBE -> RELEASE -> IDLE.
- Phase counter is 8 bits. SETUP and RELEASE each last PHASE_CYCLES cycles; STROBE lasts 2*PHASE_CYCLES cycles.
- IDLE:
  - When req=1, capture we/addr/wdata, set busy=1 and enter SETUP on the next cycle.
  - req while busy=1 is ignored (not queued).
- SETUP:
  - Drive address onto bank2/bank3.
  - nRD, nWR and nCS stay high.
  - PHI=1.
- STROBE:
  - nCS=0 iff addr[15:13]==3'b101 (A000-BFFF).
  - Read: nRD=0, bank1_dir=0. rdata is latched from bank1_in on the last STROBE cycle.
  - Write: nWR=0, bank1_dir=1, bank1_out=wdata.
  - PHI=0.
- RELEASE:
  - nRD, nWR and nCS return high.
  - Address is held.
  - For writes, bank1_dir and data are held through the end of RELEASE, giving hold time.
  - PHI=1.
- Completion:
  - On the last RELEASE cycle, transition to IDLE.
  - done=1 for exactly one cycle, coincident with busy falling to 0 on the same edge.
  - busy=1 for 4*PHASE_CYCLES cycles total.
  - A new req may be sampled in the cycle after done.
- Address lines keep their last value while in IDLE.
- nRD and nWR are never low at the same time.
- nCS is never low outside STROBE.
- With PHASE_CYCLES=1, STROBE is 2 cycles and the cycle is 4 cycles total.

Optional Feature:
- Macro: CART_BUS_BURST_EN.
- When defined:
  - Adds input req_len[7:0] (count-1) and output rvalid (1 bit).
  - A read request performs req_len+1 back-to-back read cycles with address auto-incrementing by 1; 0xFFFF wraps to 0x0000.
  - rvalid pulses for one cycle with each new rdata.
  - done and busy=0 occur only after the final byte.
  - Writes ignore req_len and perform a single cycle.
  - Reset mid-burst aborts with no further rvalid.
- When undefined:
  - Ports req_len and rvalid are absent.
  - Every request is a single cycle.

Test Plan:
- Read A=0x0147, bank1_in=0x1C, PHASE_CYCLES=4 -> busy high for 16 cycles; nRD low for cycles 5-12; nCS stays 1; done pulse; rdata=0x1C.
- Write A=0x4000, D=0x05 -> nWR low 8 cycles; bank1_dir=1 from STROBE through RELEASE end; bank1_out=0x05; nCS=1; bank2/3=0x40/0x00.
- Read A=0xA123 -> nCS=0 only during STROBE; bank2/3=0xA1/0x23.
- req held high continuously -> back-to-back transactions with exactly one idle cycle between done and the next SETUP; req while busy is ignored.
- reset asserted in the third STROBE cycle of a write -> next cycle nWR=1, bank1_dir=0, busy=0, no done.
- [CART_BUS_BURST_EN] read A=0xFFFE, req_len=2 -> addresses 0xFFFE, 0xFFFF, 0x0000; three rvalid pulses; one done after 48 cycles.

Source files
------------

// File: rtl/cart_bus_master_if.sv
// Request/response handshake between a host-side agent and cart_bus_master.
// The requester uses the master modport; cart_bus_master uses the slave one.
// req_len and rvalid exist only when CART_BUS_BURST_EN is defined.
interface cart_bus_master_if;
  logic        req;
  logic        req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        busy;
  logic        done;
  logic [7:0]  rdata;
`ifdef CART_BUS_BURST_EN
  logic [7:0]  req_len;
  logic        rvalid;

  modport master (
    output req, req_we, req_addr, req_wdata, req_len,
    input  busy, done, rdata, rvalid
  );
  modport slave (
    input  req, req_we, req_addr, req_wdata, req_len,
    output busy, done, rdata, rvalid
  );
`else
  modport master (
    output req, req_we, req_addr, req_wdata,
    input  busy, done, rdata
  );
  modport slave (
    input  req, req_we, req_addr, req_wdata,
    output busy, done, rdata
  );
`endif
endinterface

// File: rtl/cart_bus_master.sv
// Console-side initiator for timed Game Boy cartridge read/write cycles.
// Each access is SETUP (PHASE_CYCLES) -> STROBE (2*PHASE_CYCLES) ->
// RELEASE (PHASE_CYCLES); every pin and handshake output is a flop.
// Optional macro CART_BUS_BURST_EN adds multi-byte auto-incrementing reads
// (req_len / rvalid on the interface).
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | pins parked, address held, waiting for req
// SETUP   | address driven, PHI=1, all strobes high
// STROBE  | PHI=0, nRD or nWR low, nCS low for A000-BFFF; two half-phases
// RELEASE | strobes high, PHI=1, address and write data held
module cart_bus_master #(
  parameter int PHASE_CYCLES = 4  // legal 1..255
) (
  input  logic             clk_sys,
  input  logic             reset,
  cart_bus_master_if.slave bus,
  output logic [7:4]       cart_tran_bank0_out,
  input  logic [7:0]       cart_tran_bank1_in,
  output logic [7:0]       cart_tran_bank1_out,
  output logic             cart_tran_bank1_dir,
  output logic [7:0]       cart_tran_bank2_out,
  output logic [7:0]       cart_tran_bank3_out
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;

  // The phase counter is 8 bits, so STROBE is timed as two back-to-back
  // phases rather than one count of 2*PHASE_CYCLES.
  localparam logic [7:0] PC_LAST = 8'(PHASE_CYCLES - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        strobe_2nd;
  logic        we_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        phi;
  logic        n_wr;
  logic        n_rd;
  logic        n_cs;
  logic [7:0]  data_out;
  logic        data_dir;
  logic        busy_q;
  logic        done_q;
  logic [7:0]  rdata_q;
  logic        more_bytes;

`ifdef CART_BUS_BURST_EN
  logic [7:0]  left_q;
  logic        rvalid_q;

  assign more_bytes = (left_q != 8'd0);
  assign bus.rvalid = rvalid_q;
`else
  assign more_bytes = 1'b0;
`endif

  // Cart RAM / external window A000-BFFF is the only region that gets nCS.
  function automatic logic in_ram_window(input logic [15:0] a);
    return a[15:13] == 3'b101;
  endfunction

  // Sequencer: phase timing, pin drive and handshake outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      strobe_2nd <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      phi        <= 1'b0;
      n_wr       <= 1'b1;
      n_rd       <= 1'b1;
      n_cs       <= 1'b1;
      data_out   <= '0;
      data_dir   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rdata_q    <= '0;
`ifdef CART_BUS_BURST_EN
      left_q     <= '0;
      rvalid_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef CART_BUS_BURST_EN
      rvalid_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // The cycle carrying done is not an accept cycle, so a req held
          // high leaves one clear idle cycle before the next SETUP.
          if (bus.req && !done_q) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
`ifdef CART_BUS_BURST_EN
            left_q  <= bus.req_we ? 8'd0 : bus.req_len;
`endif
            busy_q  <= 1'b1;
            phi     <= 1'b1;
            cnt     <= PC_LAST;
            state   <= SETUP;
          end
        end

        SETUP: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            state      <= STROBE;
            cnt        <= PC_LAST;
            strobe_2nd <= 1'b0;
            phi        <= 1'b0;
            n_cs       <= ~in_ram_window(addr_q);
            if (we_q) begin
              n_wr     <= 1'b0;
              data_out <= wdata_q;
              data_dir <= 1'b1;
            end else begin
              n_rd <= 1'b0;
            end
          end
        end

        STROBE: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (!strobe_2nd) begin
            strobe_2nd <= 1'b1;
            cnt        <= PC_LAST;
          end else begin
            state <= RELEASE;
            cnt   <= PC_LAST;
            phi   <= 1'b1;
            n_wr  <= 1'b1;
            n_rd  <= 1'b1;
            n_cs  <= 1'b1;
            if (!we_q) begin
              rdata_q <= cart_tran_bank1_in;
`ifdef CART_BUS_BURST_EN
              rvalid_q <= 1'b1;
`endif
            end
          end
        end

        RELEASE: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (more_bytes) begin
            // Next byte of a read burst starts straight away; 0xFFFF wraps.
`ifdef CART_BUS_BURST_EN
            left_q <= left_q - 8'd1;
`endif
            addr_q <= addr_q + 16'd1;
            cnt    <= PC_LAST;
            state  <= SETUP;
          end else begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            phi      <= 1'b0;
            data_dir <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign cart_tran_bank0_out = {phi, n_wr, n_rd, n_cs};
  assign cart_tran_bank1_out = data_out;
  assign cart_tran_bank1_dir = data_dir;
  assign cart_tran_bank2_out = addr_q[15:8];
  assign cart_tran_bank3_out = addr_q[7:0];
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.rdata           = rdata_q;

endmodule

// File: tb/tb_cart_bus_master.sv
// Self-checking bench for cart_bus_master: main instance at PHASE_CYCLES=4,
// a second instance at PHASE_CYCLES=1 for the minimum-timing case.
module tb_cart_bus_master;
  localparam int P = 4;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic       reset;
  logic [7:0] b1_in;

  cart_bus_master_if bus ();
  logic [7:4] b0;
  logic [7:0] b1_out, b2, b3;
  logic       b1_dir;

  cart_bus_master #(.PHASE_CYCLES(P)) dut (
    .clk_sys(clk_sys), .reset(reset), .bus(bus),
    .cart_tran_bank0_out(b0), .cart_tran_bank1_in(b1_in),
    .cart_tran_bank1_out(b1_out), .cart_tran_bank1_dir(b1_dir),
    .cart_tran_bank2_out(b2), .cart_tran_bank3_out(b3)
  );

  cart_bus_master_if bus1 ();
  logic [7:4] c0;
  logic [7:0] c1_out, c2, c3;
  logic       c1_dir;

  cart_bus_master #(.PHASE_CYCLES(1)) dut1 (
    .clk_sys(clk_sys), .reset(reset), .bus(bus1),
    .cart_tran_bank0_out(c0), .cart_tran_bank1_in(b1_in),
    .cart_tran_bank1_out(c1_out), .cart_tran_bank1_dir(c1_dir),
    .cart_tran_bank2_out(c2), .cart_tran_bank3_out(c3)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] last_rd;

  // Reference: pin levels {PHI,nWR,nRD,nCS} in cycle k (1-based) of a
  // transaction whose phase length is p.
  function automatic logic [3:0] exp_ctl(input int k, input int p,
                                         input logic we, input logic [15:0] a);
    bit strobe;
    bit ram;
    strobe = (k > p) && (k <= 3 * p);
    ram    = (a >= 16'hA000) && (a <= 16'hBFFF);
    if (strobe) return {1'b0, ~we, we, ~ram};
    return 4'b1111;
  endfunction

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // One full transaction on the main instance, checked cycle by cycle.
  task automatic do_txn(input string name, input logic we, input logic [15:0] a,
                        input logic [7:0] d, input bit fixed_in, input logic [7:0] din);
    logic [7:0]  exp_rd;
    logic [22:0] got, exp;
    bus.req = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = d;
    step();
    bus.req = 1'b0; bus.req_addr = 16'($urandom); bus.req_wdata = 8'($urandom);
    exp_rd = last_rd;
    for (int k = 1; k <= 4 * P; k++) begin
      b1_in = fixed_in ? din : 8'($urandom);
      if (k == 3 * P && !we) exp_rd = b1_in;
      got = {bus.busy, bus.done, b0, b1_dir, b2, b3};
      exp = {1'b1, 1'b0, exp_ctl(k, P, we, a), we && (k > P), a};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s pins k=%0d: got %h expected %h", name, k, got, exp);
      end
      if (we && k > P) begin
        checks++;
        if (b1_out !== d) begin
          errors++;
          $display("FAIL %s wdata k=%0d: got %h expected %h", name, k, b1_out, d);
        end
      end
      step();
    end
    checks++;
    if ({bus.busy, bus.done, bus.rdata} !== {1'b0, 1'b1, exp_rd}) begin
      errors++;
      $display("FAIL %s end busy/done/rdata: got %b/%b/%h expected 0/1/%h",
               name, bus.busy, bus.done, bus.rdata, exp_rd);
    end
    last_rd = exp_rd;
    step();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL %s done width: got %b expected 0", name, bus.done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++;
    if ({bus.busy, bus.done, bus.rdata, b0, b1_out, b1_dir, b2, b3} !==
        {1'b0, 1'b0, 8'h00, 4'b0111, 8'h00, 1'b0, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL reset main: got %b%b %h %b %h %b %h %h expected 00 00 0111 00 0 00 00",
               bus.busy, bus.done, bus.rdata, b0, b1_out, b1_dir, b2, b3);
    end
    checks++;
    if ({bus1.busy, bus1.done, bus1.rdata, c0, c1_out, c1_dir, c2, c3} !==
        {1'b0, 1'b0, 8'h00, 4'b0111, 8'h00, 1'b0, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL reset p1: got %b%b %h %b expected 00 00 0111", bus1.busy, bus1.done, bus1.rdata, c0);
    end
    reset = 1'b0;
    last_rd = 8'h00;
    step();
  endtask

  task automatic test_spec_vectors();
    do_txn("read_0147", 1'b0, 16'h0147, 8'h00, 1'b1, 8'h1C);
    do_txn("write_4000", 1'b1, 16'h4000, 8'h05, 1'b0, 8'h00);
    do_txn("read_A123", 1'b0, 16'hA123, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic test_cs_window();
    do_txn("cs_9FFF", 1'b0, 16'h9FFF, 8'h00, 1'b0, 8'h00);
    do_txn("cs_A000", 1'b1, 16'hA000, 8'h5A, 1'b0, 8'h00);
    do_txn("cs_BFFF", 1'b0, 16'hBFFF, 8'h00, 1'b0, 8'h00);
    do_txn("cs_C000", 1'b1, 16'hC000, 8'hA5, 1'b0, 8'h00);
  endtask

  task automatic test_random();
    logic [15:0] a;
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 1) a = 16'hA000 + 16'($urandom_range(0, 16'h1FFF));
      else a = 16'($urandom);
      do_txn("random", 1'($urandom_range(0, 1)), a, 8'($urandom), 1'b0, 8'h00);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int bad;
    b1_in = 8'h3C;
    bus.req = 1'b1; bus.req_we = 1'b0; bus.req_addr = 16'h1234; bus.req_wdata = 8'h00;
    n = 0;
    while (!bus.busy && n < 10) begin step(); n++; end
    bus.req_addr = 16'hA0F0;
    n = 0; bad = 0;
    while (bus.busy && n < 100) begin
      if ({b2, b3} !== 16'h1234) bad++;
      step(); n++;
    end
    checks++;
    if (n != 4 * P || bad != 0) begin
      errors++;
      $display("FAIL b2b first: busy cycles %0d addr slips %0d expected %0d and 0", n, bad, 4 * P);
    end
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL b2b done: got %b expected 1", bus.done);
    end
    n = 0;
    while (!bus.busy && n < 20) begin step(); n++; end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL b2b gap: got %0d busy-low cycles expected 2", n);
    end
    checks++;
    if ({b2, b3} !== 16'hA0F0) begin
      errors++;
      $display("FAIL b2b second addr: got %h expected a0f0", {b2, b3});
    end
    bus.req = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin step(); n++; end
    checks++;
    if (n != 4 * P) begin
      errors++;
      $display("FAIL b2b second len: got %0d expected %0d", n, 4 * P);
    end
    bad = 0;
    for (int i = 0; i < 3 * P; i++) begin
      if (bus.busy !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b not queued: got %0d busy cycles expected 0", bad);
    end
    last_rd = 8'h3C;
  endtask

  task automatic test_reset_mid();
    int bad;
    bus.req = 1'b1; bus.req_we = 1'b1; bus.req_addr = 16'h4000; bus.req_wdata = 8'h05;
    step();
    bus.req = 1'b0;
    for (int k = 1; k < P + 3; k++) step();
    checks++;
    if ({b0, b1_dir} !== {4'b0011, 1'b1}) begin
      errors++;
      $display("FAIL rstmid pre: got %b/%b expected 0011/1", b0, b1_dir);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({bus.busy, bus.done, b0, b1_dir, bus.rdata} !== {1'b0, 1'b0, 4'b0111, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL rstmid post: got %b%b %b %b %h expected 00 0111 0 00",
               bus.busy, bus.done, b0, b1_dir, bus.rdata);
    end
    bad = 0;
    for (int i = 0; i < 4 * P; i++) begin
      step();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rstmid no done: got %0d active cycles expected 0", bad);
    end
    last_rd = 8'h00;
  endtask

  task automatic test_phase1();
    logic [7:0] exp_rd;
    logic [4:0] got, exp;
    exp_rd = 8'h00;
    bus1.req = 1'b1; bus1.req_we = 1'b0; bus1.req_addr = 16'hA001; bus1.req_wdata = 8'h00;
    step();
    bus1.req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      b1_in = 8'($urandom);
      if (k == 3) exp_rd = b1_in;
      got = {bus1.busy, c0};
      exp = {1'b1, exp_ctl(k, 1, 1'b0, 16'hA001)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL p1 pins k=%0d: got %b expected %b", k, got, exp);
      end
      step();
    end
    checks++;
    if ({bus1.busy, bus1.done, bus1.rdata} !== {1'b0, 1'b1, exp_rd}) begin
      errors++;
      $display("FAIL p1 end: got %b/%b/%h expected 0/1/%h", bus1.busy, bus1.done, bus1.rdata, exp_rd);
    end
    step();
  endtask

`ifdef CART_BUS_BURST_EN
  task automatic test_burst();
    logic [7:0]  exp_rd;
    logic [15:0] ea;
    logic [22:0] got, exp;
    int b, k, nval;
    exp_rd = 8'h00; nval = 0;
    bus.req = 1'b1; bus.req_we = 1'b0; bus.req_addr = 16'hFFFE; bus.req_len = 8'd2;
    step();
    bus.req = 1'b0; bus.req_len = 8'($urandom);
    for (int c = 1; c <= 12 * P; c++) begin
      b  = (c - 1) / (4 * P);
      k  = (c - 1) % (4 * P) + 1;
      ea = 16'hFFFE + 16'(b);
      b1_in = 8'($urandom);
      got = {bus.busy, bus.done, b0, b1_dir, b2, b3};
      exp = {1'b1, 1'b0, exp_ctl(k, P, 1'b0, ea), 1'b0, ea};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL burst pins c=%0d: got %h expected %h", c, got, exp);
      end
      checks++;
      if (bus.rvalid !== 1'(k == 3 * P + 1)) begin
        errors++;
        $display("FAIL burst rvalid c=%0d: got %b expected %b", c, bus.rvalid, k == 3 * P + 1);
      end
      if (bus.rvalid === 1'b1) begin
        nval++;
        checks++;
        if (bus.rdata !== exp_rd) begin
          errors++;
          $display("FAIL burst rdata c=%0d: got %h expected %h", c, bus.rdata, exp_rd);
        end
      end
      if (k == 3 * P) exp_rd = b1_in;
      step();
    end
    checks++;
    if ({bus.busy, bus.done, bus.rvalid} !== 3'b010 || nval != 3) begin
      errors++;
      $display("FAIL burst end: got busy/done/rvalid %b%b%b pulses %0d expected 010 and 3",
               bus.busy, bus.done, bus.rvalid, nval);
    end
    bus.req_len = 8'd0;
    last_rd = exp_rd;
    step();
  endtask
`endif

  initial begin
    reset = 1'b1;
    b1_in = 8'h00;
    bus.req = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus1.req = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
`ifdef CART_BUS_BURST_EN
    bus.req_len = 8'd0;
    bus1.req_len = 8'd0;
`endif
    last_rd = 8'h00;
    test_reset();
    test_spec_vectors();
    test_cs_window();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_phase1();
`ifdef CART_BUS_BURST_EN
    test_burst();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
